// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects and memory-wait FSM states.
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding selects; MEM-stage result takes priority over WB.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdM,
    input  logic       RegwriteM,
    input  logic [4:0] RdW,
    input  logic       RegwriteW,
    output logic [1:0] fwdAE,
    output logic [1:0] fwdBE
);

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rdm, input logic wm,
                                           input logic [4:0] rdw, input logic ww);
        if (wm && (rdm != 5'd0) && (rdm == rs))
            return FWD_MEM;
        else if (ww && (rdw != 5'd0) && (rdw == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        fwdAE = fwd_sel(Rs1E, RdM, RegwriteM, RdW, RegwriteW);
        fwdBE = fwd_sel(Rs2E, RdM, RegwriteM, RdW, RegwriteW);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller: stall/flush generation, forwarding, data-memory wait sequencing with timeout.
// Optional HAZ_PERF_EN adds saturating stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 8
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic       loadE,
    input  logic       pcsrcE,
    input  logic [4:0] RdM,
    input  logic       RegwriteM,
    input  logic       dmem_reqM,
    input  logic       dmem_ready,
    input  logic [4:0] RdW,
    input  logic       RegwriteW,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       flushD,
    output logic       flushE,
    output logic       flushW,
    output logic [1:0] fwdAE,
    output logic [1:0] fwdBE,
    output logic       mem_err
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam logic [CNT_W-1:0] WCNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    hz_state_t        state;
    logic [CNT_W-1:0] wcnt;
    logic             mem_err_q;
    logic             lw_stall;
    logic             mem_stall;
    logic [1:0]       fwd_a_raw;
    logic [1:0]       fwd_b_raw;

    fwd_unit u_fwd (
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdM       (RdM),
        .RegwriteM (RegwriteM),
        .RdW       (RdW),
        .RegwriteW (RegwriteW),
        .fwdAE     (fwd_a_raw),
        .fwdBE     (fwd_b_raw)
    );

    assign lw_stall  = loadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_stall = dmem_reqM && !dmem_ready && (state != ABORT);

    // Outputs are forced quiet while rst is high, even though state only clears on the edge.
    assign fwdAE   = rst ? FWD_RF : fwd_a_raw;
    assign fwdBE   = rst ? FWD_RF : fwd_b_raw;
    assign mem_err = mem_err_q && !rst;

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushW = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (pcsrcE) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (lw_stall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wcnt      <= '0;
            mem_err_q <= 1'b0;
        end else begin
            mem_err_q <= 1'b0;
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state <= WAIT;
                        wcnt  <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (dmem_ready) begin
                        state <= RUN;
                        wcnt  <= '0;
                    end else if (wcnt == WCNT_LAST) begin
                        state     <= ABORT;
                        mem_err_q <= 1'b1;
                    end else begin
                        wcnt <= wcnt + CNT_W'(1);
                    end
                end
                ABORT: begin
                    state <= RUN;
                    wcnt  <= '0;
                end
                default: begin
                    state <= RUN;
                    wcnt  <= '0;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stallF && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flushD && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule
